// File: rtl/pipe_pkg.sv
// Purpose: shared pipeline defaults (PC width, reset PC, bubble word) and fetch FSM encoding.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package pipe_pkg;

    localparam int unsigned          DEF_PC_WIDTH  = 32;
    localparam logic [31:0]          DEF_RESET_PC  = 32'h0000_0000;
    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0]          DEF_NOP_INSTR = 32'h0000_0000;

    // BOOT spends exactly one cycle after reset with no fetch outstanding.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

    // Saturating increment for 32-bit event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Purpose: IF/ID pipeline register with hold (keep everything) and bubble (NOP, valid=0).
// Latency: one cycle from load inputs to outputs.
// Backpressure: hold freezes the register; hold overrides bubble, bubble overrides load.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter int unsigned             W         = DEF_PC_WIDTH,
    parameter logic [W-1:0]            NOP_INSTR = W'(DEF_NOP_INSTR)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] load_instr,
    input  logic [W-1:0] load_pc_plus4,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc_plus4,
    output logic         valid,
    output logic         load_vld
);

    logic [W-1:0] instr_q,    instr_d;
    logic [W-1:0] pc_plus4_q, pc_plus4_d;
    logic         valid_q,    valid_d;

    // Next-value selection: hold > bubble > real load; a bubble leaves pc_plus4 untouched.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        load_vld   = 1'b0;
        if (hold) begin
            instr_d    = instr_q;
        end else if (bubble) begin
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end else begin
            instr_d    = load_instr;
            pc_plus4_d = load_pc_plus4;
            valid_d    = 1'b1;
            load_vld   = 1'b1;
        end
    end

    // Register state; reset empties the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Purpose: instruction fetch stage: PC register, BOOT/FETCH/WAIT FSM, IF/ID register, delivery counter.
// Latency: instruction at imem_addr appears on if_id_* one cycle later when imem_ready=1.
// Backpressure: hold_pc/hold_if freeze PC and IF/ID; imem_ready=0 stalls the PC and inserts bubbles.
module if_stage
    import pipe_pkg::*;
#(
    parameter int unsigned                PC_WIDTH  = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]        RESET_PC  = PC_WIDTH'(DEF_RESET_PC),
    parameter logic [PC_WIDTH-1:0]        NOP_INSTR = PC_WIDTH'(DEF_NOP_INSTR)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hold_pc,
    input  logic                hold_if,
    input  logic                if_flush,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [PC_WIDTH-1:0] imem_rdata,
    input  logic                imem_ready,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0] if_id_pc_plus4,
    output logic                if_id_valid,
    output logic [31:0]         fetch_cnt
);

    fetch_state_e         state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [31:0]          fetch_cnt_q, fetch_cnt_d;
    logic [PC_WIDTH-1:0]  pc_plus4;
    logic                 if_bubble;
    logic                 if_load_vld;

    // Natural wrap modulo 2^PC_WIDTH from the truncating add.
    assign pc_plus4 = pc_q + PC_WIDTH'(4);

    // FSM next state and request; a flush in WAIT abandons the stalled fetch unless PC is held.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH, ST_WAIT: begin
                imem_req = 1'b1;
                if (if_flush && !hold_pc) begin
                    state_d = ST_FETCH;
                end else if (!imem_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Next PC: hold > flush redirect > memory stall > sequential; BOOT keeps the reset PC.
    always_comb begin
        pc_d = pc_q;
        if (state_q == ST_BOOT) begin
            pc_d = pc_q;
        end else if (hold_pc) begin
            pc_d = pc_q;
        end else if (if_flush) begin
            pc_d = branch_target;
        end else if (!imem_ready) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4;
        end
    end

    // Anything other than a completed, unflushed fetch becomes a bubble.
    assign if_bubble = if_flush || !imem_ready || (state_q == ST_BOOT);

    // Count only real instructions handed to ID, sticking at all-ones.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (if_load_vld) begin
            fetch_cnt_d = sat_inc32(fetch_cnt_q);
        end
    end

    // State, PC and counter registers; reset discards any in-flight fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    if_id_reg #(
        .W         (PC_WIDTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .hold          (hold_if),
        .bubble        (if_bubble),
        .load_instr    (imem_rdata),
        .load_pc_plus4 (pc_plus4),
        .instr         (if_id_instr),
        .pc_plus4      (if_id_pc_plus4),
        .valid         (if_id_valid),
        .load_vld      (if_load_vld)
    );

    assign imem_addr = pc_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, program-counter and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0000, bubble instruction (sll $0,$0,0).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 hold_pc  input  1  from hazard detection; freeze PC.
REQ-007 hold_if  input  1  from hazard detection; freeze IF/ID register.
REQ-008 if_flush  input  1  from hazard detection; branch taken in ID, kill fetched instruction.
REQ-009 branch_target  input  PC_WIDTH  redirect address, valid with if_flush.
REQ-010 imem_rdata  input  PC_WIDTH  instruction word for imem_addr, same cycle.
REQ-011 imem_ready  input  1  imem_rdata valid this cycle.
REQ-012 imem_addr  output  PC_WIDTH  current PC.
REQ-013 imem_req  output  1  fetch request.
REQ-014 if_id_instr  output  PC_WIDTH  registered instruction to ID.
REQ-015 if_id_pc_plus4  output  PC_WIDTH  registered PC+4 to ID.
REQ-016 if_id_valid  output  1  if_id_instr is real (not bubble).
REQ-017 fetch_cnt  output  32  count of instructions delivered to ID.

Function
REQ-018 SHALL implement FSM states BOOT, FETCH, WAIT; BOOT->FETCH unconditionally one cycle after reset release.
REQ-019 In BOOT, imem_req SHALL be 0, PC SHALL stay RESET_PC, IF/ID SHALL hold bubble.
REQ-020 In FETCH/WAIT imem_req SHALL be 1 and imem_addr SHALL equal PC.
REQ-021 FETCH->WAIT when imem_ready=0; WAIT->FETCH when imem_ready=1; if_flush in WAIT SHALL return to FETCH at redirected PC.
REQ-022 Next PC priority: hold_pc (keep) > if_flush (branch_target) > imem_ready=0 (keep) > PC+4; PC+4 wraps modulo 2^PC_WIDTH.
REQ-023 IF/ID priority: hold_if (keep all) > if_flush (load bubble) > imem_ready=0 or BOOT (load bubble) > load {imem_rdata, PC+4, valid=1}.
REQ-024 Bubble SHALL mean if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc_plus4 unchanged.
REQ-025 hold and if_flush simultaneous: hold SHALL win; branch re-resolves next cycle.
REQ-026 Fetch-to-ID latency SHALL be exactly one cycle when imem_ready=1 and no hold/flush.
REQ-027 fetch_cnt SHALL increment on each IF/ID load with valid=1, saturating at 32'hFFFF_FFFF.
REQ-028 hold_pc=1 with hold_if=0 SHALL still follow REQ-023 (decoupled controls).

Reset
REQ-029 rst_n low SHALL asynchronously set state=BOOT, PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0, fetch_cnt=0.
REQ-030 Outputs under reset: imem_req=0, imem_addr=RESET_PC.
REQ-031 Reset mid-WAIT or mid-hold SHALL discard pending fetch; no carry-over.

Structure
REQ-032 Shared package pipe_pkg SHALL hold PC_WIDTH, NOP_INSTR, RESET_PC defaults and FSM state encoding.
REQ-033 IF/ID register with hold/bubble SHALL be sub-module if_id_reg; PC logic and FSM stay in if_stage.

Verification
REQ-034 Reset release, imem_ready=1, rdata=addr^32'hA5A5_A5A5 -> one BOOT cycle, addresses 0,4,8; if_id_instr=A5A5A5A5 with valid one cycle after addr 0.
REQ-035 hold_pc=hold_if=1 for 2 cycles at PC=0x10 -> PC stays 0x10, IF/ID unchanged, fetch_cnt frozen.
REQ-036 if_flush=1, branch_target=0x100 at PC=0x14 -> next PC=0x100, IF/ID bubble (valid=0, NOP), next valid instr from 0x100.
REQ-037 if_flush and hold_pc/hold_if both 1 -> PC and IF/ID unchanged; flush next cycle honored.
REQ-038 imem_ready=0 for 3 cycles at PC=0x20 -> state WAIT, PC held, 3 bubbles, then instr 0x20 delivered.
REQ-039 PC=32'hFFFF_FFFC, fetch -> next PC=0, if_id_pc_plus4=0; rst_n pulse mid-WAIT -> all REQ-029 values.
